instr_encoder: RTL and testbench
================================

# instr_encoder

Sequential instruction encoder and program loader for the single-cycle RISC-V core. It accepts symbolic operations (R-type ALU, ld, sd, beq) over a valid/ready handshake and encodes each into a 32-bit RV64I word. It writes each word sequentially into instruction memory through a write port. It produces exactly the opcodes and field layouts that the core's main control decoder consumes, and serves as the producing end of that interface for self-test and bring-up.

## Interface
- ADDR_W, 8, instruction-memory word-address width; capacity 2^ADDR_W words
- BASE, 0, first word address written after start
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- start  in  1  begin or restart a load session
- finish  in  1  end the session
- in_valid  in  1  operation fields valid
- in_ready  out  1  encoder can accept an operation
- op  in  2  00 R-type, 01 ld, 10 sd, 11 beq
- alu_sel  in  2  R-type only: 00 add, 01 sub, 10 and, 11 or
- rd, rs1, rs2  in  5 each  register indices; unused fields are ignored
- imm  in  12  ld/sd: signed byte offset; beq: branch offset bits [12:1]
- mem_we  out  1  instruction-memory write strobe
- mem_addr  out  ADDR_W  write word address
- mem_wdata  out  32  encoded instruction
- count  out  ADDR_W+1  words written this session
- full  out  1  count == 2^ADDR_W
- busy  out  1  state is RUN
- err  out  1  sticky: in_valid seen while full in RUN

## Operation
- States: IDLE, RUN, DONE. Reset enters IDLE.
- IDLE/DONE --start--> RUN. On entry: wptr=BASE, count=0, err=0.
- RUN --finish--> DONE. If an accept occurs in the same cycle, the word is still accepted and written.
- start in RUN restarts the session: wptr=BASE, count=0, err=0. A write registered in the previous cycle still completes.
- start has priority over finish.
- in_ready = (state==RUN) & ~full. Accept = in_valid & in_ready.
- Encoding (opcode; funct3; other fields):
  - R-type: 0110011; funct3 add/sub=000, and=111, or=110; funct7=0100000 for sub, else 0000000; layout {funct7,rs2,rs1,funct3,rd,op}
  - ld: 0000011; funct3 011; layout {imm,rs1,011,rd,op}
  - sd: 0100011; funct3 011; layout {imm[11:5],rs2,rs1,011,imm[4:0],op}
  - beq: 1100011; funct3 000; layout {imm[11],imm[9:4],rs2,rs1,000,imm[3:0],imm[10],op}
- Each accept writes to wptr, then wptr+1 and count+1.
- wptr never wraps: accepts stop at full.
- in_valid while full in RUN sets err. err holds until the next start or reset.
- No accepts occur in IDLE or DONE. in_valid in those states is ignored and does not set err.

## Timing
- Latency: accept at edge N produces mem_we=1 with mem_addr/mem_wdata valid for exactly the cycle after edge N.
- mem_we is registered. One word per cycle is sustained while in_valid stays high and the block is not full.
- count and full update on the same edge that asserts mem_we for the word.
- full therefore drops in_ready in the cycle after the last accept.
- Reset values: state IDLE, in_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, count 0, full 0, busy 0, err 0.
- rst asserted mid-write aborts the write: mem_we clears immediately, asynchronously.
- mem_addr/mem_wdata hold their last value when mem_we=0.

## Test plan
- Reset, then start. Send add x3,x1,x2 (op=00, alu_sel=00, rd=3, rs1=1, rs2=2). Expected: next cycle mem_we=1, mem_addr=0, mem_wdata=0x002081B3, count=1.
- Back-to-back stream, one accept per cycle, no gaps:
  - sub x5,x6,x7 -> 0x407302B3
  - ld x5,8(x10) -> 0x00853283
  - sd x5,16(x10) -> 0x00553823
  - beq x1,x2,-8 (imm=0xFFC) -> 0xFE208CE3
  - Expected: addresses BASE..BASE+3, count=4.
- ADDR_W=2: accept 4 words. Expected: full=1, in_ready=0. Hold in_valid 3 more cycles: err=1, no mem_we, count stays 4.
- Assert finish together with an accepted op. Expected: the word is written, state DONE, busy=0, in_ready=0. Later in_valid produces no writes and leaves err at 0.
- In RUN with count=3, pulse start. Expected: next accept writes to BASE, count=1, err cleared.
- Assert rst asynchronously in the cycle where mem_we=1. Expected: mem_we and all outputs return to their reset values before the next edge.

Source files
------------

// File: rtl/instr_encoder_if.sv
// ============================================================================
// Module   : instr_encoder_if
// Purpose  : Operation handshake and instruction-memory write bus for the
//            RV64I instruction encoder / program loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface instr_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              finish;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        op;
  logic [1:0]        alu_sel;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [11:0]       imm;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              busy;
  logic              err;

  // Operation source / memory sink side
  modport master (
    output start, finish, in_valid, op, alu_sel, rd, rs1, rs2, imm,
    input  in_ready, mem_we, mem_addr, mem_wdata, count, full, busy, err
  );

  // Encoder side
  modport slave (
    input  start, finish, in_valid, op, alu_sel, rd, rs1, rs2, imm,
    output in_ready, mem_we, mem_addr, mem_wdata, count, full, busy, err
  );
endinterface

`default_nettype wire

// File: rtl/instr_encoder.sv
// ============================================================================
// Module   : instr_encoder
// Purpose  : Encodes symbolic R-type/ld/sd/beq operations into RV64I words and
//            writes them sequentially into instruction memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module instr_encoder #(
  parameter int ADDR_W = 8,
  parameter int BASE   = 0
) (
  input  wire logic      clk,
  input  wire logic      rst,
  instr_encoder_if.slave bus
);

  localparam logic [ADDR_W-1:0] c_base    = ADDR_W'(BASE);
  localparam logic [ADDR_W:0]   c_cap     = (ADDR_W+1)'(1) << ADDR_W;
  localparam logic [6:0]        c_opc_r   = 7'b0110011;
  localparam logic [6:0]        c_opc_ld  = 7'b0000011;
  localparam logic [6:0]        c_opc_sd  = 7'b0100011;
  localparam logic [6:0]        c_opc_beq = 7'b1100011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W:0]   r_count;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic              r_err;

  logic              w_busy;
  logic              w_full;
  logic              w_ready;
  logic              w_accept;
  logic [ADDR_W-1:0] w_ptr_sel;
  logic [ADDR_W:0]   w_cnt_sel;
  logic [2:0]        w_f3;
  logic [6:0]        w_f7;
  logic [31:0]       w_word;

  assign w_busy   = (r_state == S_RUN);
  assign w_full   = (r_count == c_cap);
  assign w_ready  = w_busy & ~w_full;
  assign w_accept = bus.in_valid & w_ready;

  // An accept coinciding with a restart lands at the start of the new session.
  assign w_ptr_sel = bus.start ? c_base : r_wptr;
  assign w_cnt_sel = bus.start ? '0     : r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.start) begin
      w_state_nxt = S_RUN;
    end else if (bus.finish && (r_state == S_RUN)) begin
      w_state_nxt = S_DONE;
    end
  end

  always_comb begin
    w_f3   = 3'b000;
    w_f7   = 7'b0000000;
    w_word = 32'd0;
    case (bus.op)
      2'b00: begin
        case (bus.alu_sel)
          2'b10:   w_f3 = 3'b111;
          2'b11:   w_f3 = 3'b110;
          default: w_f3 = 3'b000;
        endcase
        if (bus.alu_sel == 2'b01) begin
          w_f7 = 7'b0100000;
        end
        w_word = {w_f7, bus.rs2, bus.rs1, w_f3, bus.rd, c_opc_r};
      end
      2'b01: begin
        w_word = {bus.imm, bus.rs1, 3'b011, bus.rd, c_opc_ld};
      end
      2'b10: begin
        w_word = {bus.imm[11:5], bus.rs2, bus.rs1, 3'b011, bus.imm[4:0], c_opc_sd};
      end
      default: begin
        // imm carries branch offset bits [12:1]
        w_word = {bus.imm[11], bus.imm[9:4], bus.rs2, bus.rs1, 3'b000,
                  bus.imm[3:0], bus.imm[10], c_opc_beq};
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr      <= c_base;
      r_count     <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 32'd0;
      r_err       <= 1'b0;
    end else begin
      r_mem_we <= w_accept;
      if (w_accept) begin
        r_mem_addr  <= w_ptr_sel;
        r_mem_wdata <= w_word;
        r_wptr      <= w_ptr_sel + ADDR_W'(1);
        r_count     <= w_cnt_sel + (ADDR_W+1)'(1);
      end else if (bus.start) begin
        r_wptr  <= c_base;
        r_count <= '0;
      end

      if (bus.start) begin
        r_err <= 1'b0;
      end else if (w_busy && bus.in_valid && w_full) begin
        r_err <= 1'b1;
      end
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.busy      = w_busy;
  assign bus.full      = w_full;
  assign bus.count     = r_count;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// ============================================================================
// Module   : tb_instr_encoder
// Purpose  : Scoreboard bench for instr_encoder with a 4-word memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_instr_encoder;

  localparam int AW = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  instr_encoder_if #(.ADDR_W(AW)) bus ();

  instr_encoder #(.ADDR_W(AW), .BASE(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [AW:0]   cnt;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected word
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0 && bus.mem_we === 1'b1) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got mem_we=1 addr=%0d data=0x%0h, expected no write",
                 bus.mem_addr, bus.mem_wdata);
      end else begin
        e = sb.pop_front();
        chk("wr_addr",  32'(bus.mem_addr), 32'(e.addr));
        chk("wr_data",  bus.mem_wdata,     e.data);
        chk("wr_count", 32'(bus.count),    32'(e.cnt));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [1:0] op, input logic [1:0] alu,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [11:0] imm, input logic [AW-1:0] ea,
                      input logic [31:0] ed, input logic [AW:0] ec);
    bus.op       = op;
    bus.alu_sel  = alu;
    bus.rd       = rd;
    bus.rs1      = rs1;
    bus.rs2      = rs2;
    bus.imm      = imm;
    bus.in_valid = 1'b1;
    chk("in_ready_at_issue", 32'(bus.in_ready), 32'd1);
    sb.push_back({ea, ed, ec});
    tick(1);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  32'(bus.in_ready),  32'd0);
    chk({tag, "_mem_we"},    32'(bus.mem_we),    32'd0);
    chk({tag, "_mem_addr"},  32'(bus.mem_addr),  32'd0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata,      32'd0);
    chk({tag, "_count"},     32'(bus.count),     32'd0);
    chk({tag, "_full"},      32'(bus.full),      32'd0);
    chk({tag, "_busy"},      32'(bus.busy),      32'd0);
    chk({tag, "_err"},       32'(bus.err),       32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.finish   = 1'b0;
    bus.in_valid = 1'b0;
    bus.op       = 2'b00;
    bus.alu_sel  = 2'b00;
    bus.rd       = 5'd0;
    bus.rs1      = 5'd0;
    bus.rs2      = 5'd0;
    bus.imm      = 12'd0;
    tick(2);
    chk_reset_outputs("reset");
    rst = 1'b0;
    tick(1);

    // in_valid in IDLE is ignored
    bus.in_valid = 1'b1;
    tick(2);
    chk("idle_err", 32'(bus.err), 32'd0);
    chk("idle_count", 32'(bus.count), 32'd0);
    bus.in_valid = 1'b0;

    pulse_start();
    chk("run_busy", 32'(bus.busy), 32'd1);
    chk("run_in_ready", 32'(bus.in_ready), 32'd1);

    // add x3,x1,x2
    send(2'b00, 2'b00, 5'd3, 5'd1, 5'd2, 12'd0, 2'd0, 32'h002081B3, 3'd1);
    bus.in_valid = 1'b0;
    tick(1);
    chk("add_count", 32'(bus.count), 32'd1);

    // New session, back-to-back stream filling the memory
    pulse_start();
    chk("restart_count", 32'(bus.count), 32'd0);
    send(2'b00, 2'b01, 5'd5, 5'd6, 5'd7, 12'd0, 2'd0, 32'h407302B3, 3'd1);
    send(2'b01, 2'b00, 5'd5, 5'd10, 5'd0, 12'd8, 2'd1, 32'h00853283, 3'd2);
    send(2'b10, 2'b00, 5'd0, 5'd10, 5'd5, 12'd16, 2'd2, 32'h00553823, 3'd3);
    send(2'b11, 2'b00, 5'd0, 5'd1, 5'd2, 12'hFFC, 2'd3, 32'hFE208CE3, 3'd4);
    chk("full_set", 32'(bus.full), 32'd1);
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    tick(3);
    chk("full_err", 32'(bus.err), 32'd1);
    chk("full_count", 32'(bus.count), 32'd4);
    chk("hold_mem_we", 32'(bus.mem_we), 32'd0);
    chk("hold_mem_addr", 32'(bus.mem_addr), 32'd3);
    chk("hold_mem_wdata", bus.mem_wdata, 32'hFE208CE3);
    bus.in_valid = 1'b0;

    // Restart while full clears err and count
    pulse_start();
    chk("restart_err", 32'(bus.err), 32'd0);
    chk("restart_full", 32'(bus.full), 32'd0);
    chk("restart_full_count", 32'(bus.count), 32'd0);
    send(2'b00, 2'b10, 5'd1, 5'd2, 5'd3, 12'd0, 2'd0, 32'h003170B3, 3'd1);
    send(2'b00, 2'b11, 5'd4, 5'd5, 5'd6, 12'd0, 2'd1, 32'h0062E233, 3'd2);
    send(2'b10, 2'b00, 5'd0, 5'd3, 5'd2, 12'hFFC, 2'd2, 32'hFE21BE23, 3'd3);
    bus.in_valid = 1'b0;
    chk("pre_restart_count", 32'(bus.count), 32'd3);
    // Restart while the third write is still on the bus
    pulse_start();
    chk("mid_restart_count", 32'(bus.count), 32'd0);
    send(2'b01, 2'b00, 5'd5, 5'd10, 5'd0, 12'd8, 2'd0, 32'h00853283, 3'd1);

    // finish together with an accepted op
    bus.finish = 1'b1;
    send(2'b11, 2'b00, 5'd0, 5'd1, 5'd2, 12'hFFC, 2'd1, 32'hFE208CE3, 3'd2);
    bus.finish = 1'b0;
    tick(3);
    chk("done_busy", 32'(bus.busy), 32'd0);
    chk("done_in_ready", 32'(bus.in_ready), 32'd0);
    chk("done_err", 32'(bus.err), 32'd0);
    chk("done_count", 32'(bus.count), 32'd2);
    bus.in_valid = 1'b0;

    // Asynchronous reset during a write cycle
    pulse_start();
    chk("from_done_busy", 32'(bus.busy), 32'd1);
    send(2'b00, 2'b00, 5'd3, 5'd1, 5'd2, 12'd0, 2'd0, 32'h002081B3, 3'd1);
    bus.in_valid = 1'b0;
    chk("pre_rst_mem_we", 32'(bus.mem_we), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk_reset_outputs("async_rst");
    chk("aborted_pending", 32'(sb.size()), 32'd1);
    sb.delete();
    tick(1);
    rst = 1'b0;
    tick(2);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
